memory_bidi_ctrl: RTL and testbench

//  Parametrised word memory on a shared bidirectional data bus, for the CPU/bus fabric.

---
 rtl/memory_bidi_ctrl.sv | 152 +++++++++++++++
 tb/tb_memory_bidi_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bidi_ctrl.sv
// memory_bidi_ctrl: parametrised word memory on a shared bidirectional data bus.
// After reset the array is zero-filled in hardware (one word per clock) before
// ready rises. Writes complete in the accept cycle. Reads wait READ_LATENCY
// cycles and then drive the bus for as long as enable and read_write stay high.
// Accesses to addresses >= MEM_DEPTH are rejected with a one-cycle addr_err pulse.
// Optional feature macro: MEM_BYTE_WRITE_EN (adds per-byte write enables on byte_en).
module memory_bidi_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEM_DEPTH    = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    read_write,
  input  logic                    enable,
  input  logic [ADDR_WIDTH-1:0]   address,
  inout  wire  [DATA_WIDTH-1:0]   data,
  output logic                    ready,
  output logic                    addr_err
`ifdef MEM_BYTE_WRITE_EN
  ,
  input  logic [DATA_WIDTH/8-1:0] byte_en
`endif
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {CLEAR, IDLE, RWAIT, DRIVE} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      clr_ptr, clr_ptr_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [LAT_W-1:0]      lat_cnt, lat_cnt_nxt;
  logic                  ready_nxt, addr_err_nxt;
  logic                  in_range;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  rd_load;
  logic [DATA_WIDTH-1:0] rd_reg;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
`ifdef MEM_BYTE_WRITE_EN
  logic [DATA_WIDTH/8-1:0] mem_be;
`endif

  // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH still compares correctly.
  assign in_range = ({1'b0, address} < (ADDR_WIDTH+1)'(MEM_DEPTH));

  // Bus is driven only while a completed read is held by the master; the
  // enable term is combinational so the bus lets go in the cycle enable drops.
  assign data = (state == DRIVE && enable && read_write) ? rd_reg : {DATA_WIDTH{1'bz}};

  // Next-state, control outputs and memory write port selection.
  always_comb begin
    state_nxt    = state;
    clr_ptr_nxt  = clr_ptr;
    idx_nxt      = idx;
    lat_cnt_nxt  = lat_cnt;
    ready_nxt    = ready;
    addr_err_nxt = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = clr_ptr;
    mem_wdata    = '0;
    rd_load      = 1'b0;
`ifdef MEM_BYTE_WRITE_EN
    mem_be       = '1;
`endif
    unique case (state)
      CLEAR: begin
        mem_we      = 1'b1;
        clr_ptr_nxt = clr_ptr + 1'b1;
        if (clr_ptr == LAST_IDX) begin
          clr_ptr_nxt = '0;
          ready_nxt   = 1'b1;
          state_nxt   = IDLE;
        end
      end
      IDLE: begin
        if (enable) begin
          if (!in_range) begin
            addr_err_nxt = 1'b1;
          end else if (read_write) begin
            idx_nxt     = address[IDX_W-1:0];
            lat_cnt_nxt = LAT_W'(READ_LATENCY - 1);
            ready_nxt   = 1'b0;
            state_nxt   = RWAIT;
          end else begin
            mem_we    = 1'b1;
            mem_addr  = address[IDX_W-1:0];
            mem_wdata = data;
`ifdef MEM_BYTE_WRITE_EN
            mem_be    = byte_en;
`endif
          end
        end
      end
      RWAIT: begin
        if (!enable) begin
          ready_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (lat_cnt == '0) begin
          rd_load   = 1'b1;
          ready_nxt = 1'b1;
          state_nxt = DRIVE;
        end else begin
          lat_cnt_nxt = lat_cnt - 1'b1;
        end
      end
      DRIVE: begin
        if (!enable) state_nxt = IDLE;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Control registers; reset restarts the zero-fill from word 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= CLEAR;
      clr_ptr  <= '0;
      idx      <= '0;
      lat_cnt  <= '0;
      ready    <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_ptr  <= clr_ptr_nxt;
      idx      <= idx_nxt;
      lat_cnt  <= lat_cnt_nxt;
      ready    <= ready_nxt;
      addr_err <= addr_err_nxt;
    end
  end

  // Storage array and read-data register (no reset: contents come from CLEAR).
  always_ff @(posedge clk) begin
    if (mem_we) begin
`ifdef MEM_BYTE_WRITE_EN
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
`else
      mem[mem_addr] <= mem_wdata;
`endif
    end
    if (rd_load) rd_reg <= mem[idx];
  end

endmodule

// File: tb/tb_memory_bidi_ctrl.sv
// Self-checking bench for memory_bidi_ctrl: directed scenarios plus a randomized
// read/write mix checked against an array model of the memory contents.
// With MEM_BYTE_WRITE_EN defined, byte_en is exercised as well.
module tb_memory_bidi_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 256;
  localparam int RL    = 2;
  localparam logic [DW-1:0] BUS_IDLE = '1;  // value of the pulled-up bus when nobody drives

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          read_write = 1'b0;
  logic          enable = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] drv_val = '0;
  logic          drv_on = 1'b0;
  tri1  [DW-1:0] data;
  logic          ready;
  logic          addr_err;
`ifdef MEM_BYTE_WRITE_EN
  logic [DW/8-1:0] byte_en = '1;
`endif

  logic [DW-1:0] model [DEPTH];
  int n_cmp = 0;
  int n_err = 0;

  assign data = drv_on ? drv_val : {DW{1'bz}};

  always #5 clk = ~clk;

  memory_bidi_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .READ_LATENCY(RL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .read_write(read_write),
    .enable(enable),
    .address(address),
    .data(data),
    .ready(ready),
    .addr_err(addr_err)
`ifdef MEM_BYTE_WRITE_EN
    ,
    .byte_en(byte_en)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from reset release to ready; the model is zero afterwards.
  task automatic wait_clear(input string tag);
    int edges;
    edges = 0;
    while (ready !== 1'b1 && edges < DEPTH + 50) begin
      step();
      edges++;
    end
    chk(tag, edges, DEPTH);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] val);
    enable = 1'b1; read_write = 1'b0; address = addr; drv_val = val; drv_on = 1'b1;
    step();
    enable = 1'b0; drv_on = 1'b0;
    chk("wr_ready", ready, 1);
    chk("wr_addr_err", addr_err, (int'(addr) >= DEPTH));
    if (int'(addr) < DEPTH) begin
`ifdef MEM_BYTE_WRITE_EN
      for (int b = 0; b < DW/8; b++)
        if (byte_en[b]) model[int'(addr)][8*b +: 8] = val[8*b +: 8];
`else
      model[int'(addr)] = val;
`endif
    end
  endtask

  task automatic do_read(input logic [AW-1:0] addr, output logic [DW-1:0] got);
    int lat;
    logic [DW-1:0] exp;
    got = BUS_IDLE;
    enable = 1'b1; read_write = 1'b1; address = addr; drv_on = 1'b0;
    step();
    if (int'(addr) >= DEPTH) begin
      chk("rd_oor_err", addr_err, 1);
      chk("rd_oor_ready", ready, 1);
      chk("rd_oor_bus", data, BUS_IDLE);
      enable = 1'b0;
      step();
      chk("rd_oor_err_clr", addr_err, 0);
      return;
    end
    exp = model[int'(addr)];
    chk("rd_accept_ready", ready, 0);
    lat = 0;
    while (ready !== 1'b1 && lat < RL + 20) begin
      chk("rd_wait_bus", data, BUS_IDLE);
      step();
      lat++;
    end
    chk("rd_latency", lat, RL);
    got = data;
    chk("rd_data", got, exp);
    enable = 1'b0;
    #1;
    chk("rd_release", data, BUS_IDLE);
    step();
    chk("rd_idle_ready", ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] got;
    logic [AW-1:0] a;
    int lat;

    // Reset state
    repeat (3) step();
    chk("rst_ready", ready, 0);
    chk("rst_addr_err", addr_err, 0);
    chk("rst_bus", data, BUS_IDLE);
    reset = 1'b1;
    wait_clear("clear_len");

    // Zero-fill visible at both ends and in the middle
    do_read(16'h0000, got); chk("zero_0", got, 16'h0000);
    do_read(16'h0011, got); chk("zero_17", got, 16'h0000);
    do_read(16'h00FF, got); chk("zero_255", got, 16'h0000);

    // Write then read back
    do_write(16'h0012, 16'hBEEF);
    do_read(16'h0012, got); chk("beef", got, 16'hBEEF);

    // Back-to-back writes
    do_write(16'h0020, 16'h1111);
    do_write(16'h0021, 16'h2222);
    do_read(16'h0021, got); chk("b2b_1", got, 16'h2222);
    do_read(16'h0020, got); chk("b2b_0", got, 16'h1111);

    // Out-of-range write: one-cycle error, no aliasing onto word 0
    do_write(16'h0100, 16'h1234);
    step();
    chk("oor_err_pulse", addr_err, 0);
    do_read(16'h0000, got); chk("oor_no_alias", got, 16'h0000);
    do_read(16'h0100, got);

    // Read aborted after one cycle; bus never driven
    enable = 1'b1; read_write = 1'b1; address = 16'h0012;
    step();
    chk("abort_ready_low", ready, 0);
    chk("abort_bus_a", data, BUS_IDLE);
    enable = 1'b0;
    step();
    chk("abort_ready", ready, 1);
    chk("abort_bus_b", data, BUS_IDLE);
    step();
    chk("abort_bus_c", data, BUS_IDLE);
    do_write(16'h0013, 16'hC0DE);
    do_read(16'h0013, got); chk("post_abort", got, 16'hC0DE);

    // read_write dropping in DRIVE releases the bus and writes nothing
    enable = 1'b1; read_write = 1'b1; address = 16'h0012;
    step();
    lat = 0;
    while (ready !== 1'b1 && lat < RL + 20) begin step(); lat++; end
    chk("rwdrop_latency", lat, RL);
    read_write = 1'b0;
    #1;
    chk("rwdrop_bus", data, BUS_IDLE);
    step();
    enable = 1'b0;
    step();
    do_read(16'h0012, got); chk("rwdrop_nowrite", got, 16'hBEEF);

    // Randomized mix against the array model
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) < 8) a = AW'($urandom_range(0, 15));
      else if ($urandom_range(0, 1) == 1) a = AW'($urandom_range(0, DEPTH - 1));
      else a = AW'($urandom_range(DEPTH, DEPTH + 500));
`ifdef MEM_BYTE_WRITE_EN
      byte_en = (DW/8)'($urandom);
`endif
      if ($urandom_range(0, 1) == 1) do_write(a, DW'($urandom));
      else do_read(a, got);
    end
`ifdef MEM_BYTE_WRITE_EN
    byte_en = '1;
`endif

    // Reset in DRIVE: bus released and ready low at once, contents cleared
    do_write(16'h0033, 16'h5A5A);
    enable = 1'b1; read_write = 1'b1; address = 16'h0033;
    step();
    lat = 0;
    while (ready !== 1'b1 && lat < RL + 20) begin step(); lat++; end
    chk("drive_data", data, 16'h5A5A);
    reset = 1'b0;
    #1;
    chk("async_bus", data, BUS_IDLE);
    chk("async_ready", ready, 0);
    step();
    // Write request held through CLEAR must be ignored
    read_write = 1'b0; drv_val = 16'h7777; drv_on = 1'b1;
    step();
    reset = 1'b1;
    wait_clear("reclear_len");
    enable = 1'b0; drv_on = 1'b0;
    do_read(16'h0033, got); chk("reclear_zero", got, 16'h0000);
    do_read(16'h0012, got); chk("reclear_zero2", got, 16'h0000);

`ifdef MEM_BYTE_WRITE_EN
    // Partial-lane write merges into the existing word
    byte_en = 2'b11;
    do_write(16'h0040, 16'hFFFF);
    byte_en = 2'b01;
    do_write(16'h0040, 16'h00AA);
    byte_en = 2'b00;
    do_write(16'h0040, 16'h1234);
    byte_en = 2'b11;
    do_read(16'h0040, got); chk("byte_merge", got, 16'hFFAA);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
